// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if
// Bundle of request, result and status signals around the shared shift unit.
//   a_*   : requester A (execute stage): valid/ready, operand, shift amount, op
//   b_*   : requester B (address/immediate path): same fields as A
//   res_* : result channel: valid/ready, shifted value, source tag (0 = A, 1 = B)
//   busy  : unit is not idle
// Modports: master = requesters plus result consumer, slave = the shift unit.
interface shift_arbiter_if #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
);
    logic               a_valid;
    logic               a_ready;
    logic [DATA_W-1:0]  a_in;
    logic [SHAMT_W-1:0] a_shamt;
    logic [1:0]         a_op;
    logic               b_valid;
    logic               b_ready;
    logic [DATA_W-1:0]  b_in;
    logic [SHAMT_W-1:0] b_shamt;
    logic [1:0]         b_op;
    logic               res_valid;
    logic               res_ready;
    logic [DATA_W-1:0]  res_out;
    logic               res_src;
    logic               busy;

    modport master (
        output a_valid, a_in, a_shamt, a_op,
        output b_valid, b_in, b_shamt, b_op,
        output res_ready,
        input  a_ready, b_ready, res_valid, res_out, res_src, busy
    );

    modport slave (
        input  a_valid, a_in, a_shamt, a_op,
        input  b_valid, b_in, b_shamt, b_op,
        input  res_ready,
        output a_ready, b_ready, res_valid, res_out, res_src, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter
// Round-robin shares one iterative 16-bit shifter between requesters A and B.
// One logarithmic stage (2^k) is applied per cycle, selected by shamt[k].
// Ops: 00 rotate left, 01 shift left logical, 10 shift right arithmetic,
//      11 shift right logical.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_arbiter_if.slave (requests A/B, result channel, busy)
// Optional build macro SHIFT_SKIP_EN: end SHIFT as soon as no higher shamt
// bits remain set (shamt = 0 goes straight to DONE). Undefined: always 4
// SHIFT cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; grant is combinational this cycle
// SHIFT | applying stage k of the captured request, one stage per cycle
// DONE  | result presented on res_*, held until res_ready
module shift_arbiter #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic               src_q, src_d;
    logic               rr_q, rr_d;
    logic [1:0]         k_q, k_d;

    logic               grant_a, grant_b, accept;
    logic [SHAMT_W-1:0] shamt_sel;
    logic               last_stage, skip_shift;

    function automatic logic [DATA_W-1:0] shift_stage(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        op,
        input logic [1:0]        k
    );
        logic [SHAMT_W:0]    amt;
        logic [2*DATA_W-1:0] rot;
        logic [DATA_W-1:0]   r;
        amt = (SHAMT_W+1)'(1) << k;
        rot = {d, d} << amt;
        case (op)
            2'b00:   r = rot[2*DATA_W-1:DATA_W];
            2'b01:   r = d << amt;
            2'b10:   r = DATA_W'($signed(d) >>> amt);
            default: r = d >> amt;
        endcase
        return r;
    endfunction

    assign accept    = grant_a | grant_b;
    assign shamt_sel = grant_b ? bus.b_shamt : bus.a_shamt;

`ifdef SHIFT_SKIP_EN
    logic [SHAMT_W-1:0] shamt_above;
    assign shamt_above = shamt_q >> k_q;
    // Stop once no shamt bit above the current stage is left to apply.
    assign last_stage  = (k_q == 2'd3) || (shamt_above[SHAMT_W-1:1] == '0);
    assign skip_shift  = (shamt_sel == '0);
`else
    assign last_stage  = (k_q == 2'd3);
    assign skip_shift  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = skip_shift ? DONE : SHIFT;
            SHIFT:   if (last_stage) state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants are gated by rst_n so both readies stay low while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE && rst_n) begin
            grant_a = bus.a_valid & (~bus.b_valid | ~rr_q);
            grant_b = bus.b_valid & (~bus.a_valid | rr_q);
        end
        bus.a_ready   = grant_a;
        bus.b_ready   = grant_b;
        bus.res_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.res_out   = data_q;
        bus.res_src   = src_q;
    end

    always_comb begin
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        src_d   = src_q;
        rr_d    = rr_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = grant_b ? bus.b_in : bus.a_in;
                    shamt_d = shamt_sel;
                    op_d    = grant_b ? bus.b_op : bus.a_op;
                    src_d   = grant_b;
                    k_d     = 2'd0;
                end
            end
            SHIFT: begin
                if (shamt_q[k_q]) data_d = shift_stage(data_q, op_q, k_q);
                k_d = k_q + 2'd1;
            end
            DONE: begin
                k_d = 2'd0;
                if (bus.res_ready) rr_d = ~src_q;
            end
            default: k_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= 2'b00;
            src_q   <= 1'b0;
            rr_q    <= 1'b0;
            k_q     <= 2'd0;
        end else begin
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            k_q     <= k_d;
        end
    end
endmodule
